// File: rtl/sram_data_port.sv
// Data-side load/store front end for the internal SRAM: byte/half/word access, load extension, read-modify-write for sub-word stores.
// Latency (accept edge to rsp valid): load 3, word store 2, sub-word store 4, error 1; one request in flight.
// Backpressure: o_req_ready only in IDLE; the response is held until i_rsp_ready.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module sram_data_port #(
    parameter int num_words    = 4096,
    parameter int l2_num_words = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [`WORD_SIZE-1:0]   i_req_addr,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [`WORD_SIZE-1:0]   i_req_wdata,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [`WORD_SIZE-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_sram_read_enable_A,
    output logic [l2_num_words-1:0] o_sram_addr_read_A,
    input  logic [`WORD_SIZE-1:0]   i_sram_data_read_A,
    output logic                    o_sram_write_enable,
    output logic [l2_num_words-1:0] o_sram_addr_write,
    output logic [`WORD_SIZE-1:0]   o_sram_data_to_write
);

    localparam int W = `WORD_SIZE;

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RSP} state_t;

    state_t                  state, state_nxt;
    logic                    we_q;
    logic [1:0]              size_q;
    logic [1:0]              off_q;
    logic                    uns_q;
    logic [l2_num_words-1:0] widx_q;
    logic [W-1:0]            wdata_q;
    logic [W-1:0]            rdata_q;
    logic                    err_q;

    logic                    accept;
    logic                    acc_err;
    logic                    hi_nz;
    logic                    oor;
    logic [l2_num_words:0]   widx_ext;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    logic [W-1:0]            load_ext;
    logic [W-1:0]            merged;

    assign accept = (state == IDLE) && i_req_valid;

    // Address bits above the SRAM window must be zero; the widx compare also covers non-power-of-two depths.
    generate
        if (W > l2_num_words + 2) begin : g_hi
            assign hi_nz = |i_req_addr[W-1:l2_num_words+2];
        end else begin : g_nohi
            assign hi_nz = 1'b0;
        end
    endgenerate

    assign widx_ext = {1'b0, i_req_addr[l2_num_words+1:2]};
    assign oor      = widx_ext >= (l2_num_words+1)'(num_words);

    always_comb begin
        acc_err = hi_nz || oor;
        case (i_req_size)
            2'b01:   if (i_req_addr[0])          acc_err = 1'b1;
            2'b10:   if (i_req_addr[1:0] != 2'b00) acc_err = 1'b1;
            2'b11:   acc_err = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        byte_v = i_sram_data_read_A[{off_q, 3'b000} +: 8];
        half_v = i_sram_data_read_A[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_ext = uns_q ? {{(W-8){1'b0}}, byte_v}  : {{(W-8){byte_v[7]}}, byte_v};
            2'b01:   load_ext = uns_q ? {{(W-16){1'b0}}, half_v} : {{(W-16){half_v[15]}}, half_v};
            default: load_ext = i_sram_data_read_A;
        endcase
    end

    // The SRAM has no byte enables, so sub-word stores splice into the word just read.
    always_comb begin
        merged = i_sram_data_read_A;
        if (size_q == 2'b00)
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    if (acc_err)                  state_nxt = RSP;
                    else if (!i_req_we)           state_nxt = RD;
                    else if (i_req_size == 2'b10) state_nxt = WR;
                    else                          state_nxt = RD;
                end
            end
            RD:      state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = we_q ? WR : RSP;
            WR:      state_nxt = RSP;
            RSP:     if (i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready          = (state == IDLE) && i_rst_n;
        o_rsp_valid          = (state == RSP);
        o_rsp_rdata          = rdata_q;
        o_rsp_err            = err_q;
        o_sram_read_enable_A = 1'b0;
        o_sram_addr_read_A   = '0;
        o_sram_write_enable  = 1'b0;
        o_sram_addr_write    = '0;
        o_sram_data_to_write = '0;
        case (state)
            RD: begin
                o_sram_read_enable_A = 1'b1;
                o_sram_addr_read_A   = widx_q;
            end
            WR: begin
                o_sram_write_enable  = 1'b1;
                o_sram_addr_write    = widx_q;
                o_sram_data_to_write = wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= i_req_we;
                        size_q  <= i_req_size;
                        off_q   <= i_req_addr[1:0];
                        uns_q   <= i_req_unsigned;
                        widx_q  <= i_req_addr[l2_num_words+1:2];
                        wdata_q <= i_req_wdata;
                        rdata_q <= '0;
                        err_q   <= acc_err;
                    end
                end
                RD_WAIT: begin
                    if (we_q) wdata_q <= merged;
                    else      rdata_q <= load_ext;
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_data_port.sv
// Directed bench for sram_data_port with a behavioural synchronous SRAM on read port A / write port.
module tb_sram_data_port;

    localparam int W  = 32;
    localparam int NW = 4096;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [W-1:0]  req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [W-1:0]  req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_err;
    logic          sram_ren;
    logic [AW-1:0] sram_raddr;
    logic [W-1:0]  sram_rdat;
    logic          sram_wen;
    logic [AW-1:0] sram_waddr;
    logic [W-1:0]  sram_wdat;

    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [W-1:0]  bd_dat = '0;
    logic [W-1:0]  mem [0:NW-1];
    int            en_cnt = 0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sram_data_port #(.num_words(NW), .l2_num_words(AW)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_req_valid          (req_valid),
        .o_req_ready          (req_ready),
        .i_req_we             (req_we),
        .i_req_addr           (req_addr),
        .i_req_size           (req_size),
        .i_req_unsigned       (req_unsigned),
        .i_req_wdata          (req_wdata),
        .o_rsp_valid          (rsp_valid),
        .i_rsp_ready          (rsp_ready),
        .o_rsp_rdata          (rsp_rdata),
        .o_rsp_err            (rsp_err),
        .o_sram_read_enable_A (sram_ren),
        .o_sram_addr_read_A   (sram_raddr),
        .i_sram_data_read_A   (sram_rdat),
        .o_sram_write_enable  (sram_wen),
        .o_sram_addr_write    (sram_waddr),
        .o_sram_data_to_write (sram_wdat)
    );

    always @(posedge clk) begin
        if (bd_we)    mem[bd_addr] <= bd_dat;
        if (sram_wen) mem[sram_waddr] <= sram_wdat;
        if (sram_ren) sram_rdat <= mem[sram_raddr];
    end

    always @(negedge clk) begin
        if (sram_ren || sram_wen) en_cnt++;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        bd_addr = a;
        bd_dat  = d;
        bd_we   = 1'b1;
        @(posedge clk); #1;
        bd_we   = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [W-1:0] addr, input logic [1:0] size,
                          input logic uns, input logic [W-1:0] wdata,
                          output logic [W-1:0] rdata, output logic err,
                          output int lat, output int wr_lat);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        wr_lat = 0;
        while (!rsp_valid && lat < 20) begin
            if (sram_wen) wr_lat = lat;
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    typedef struct {
        logic       we;
        logic [W-1:0] addr;
        logic [1:0] size;
        string      tag;
    } err_vec_t;

    initial begin
        logic [W-1:0] rd;
        logic         er;
        int           lat, wl, e0;
        err_vec_t     ev [4];

        ev[0] = '{1'b0, 32'h0000_0002, 2'b10, "err_word_mis"};
        ev[1] = '{1'b1, 32'h0000_0005, 2'b01, "err_half_mis"};
        ev[2] = '{1'b0, 32'h0000_0000, 2'b11, "err_size11"};
        ev[3] = '{1'b0, 32'h0000_4000, 2'b10, "err_range"};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
        #3;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_sram_en", {30'd0, sram_ren, sram_wen}, 32'd0);
        #19;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, rd, er, lat, wl);
        chk("wst_lat", lat, 2);
        chk("wst_wr_cycle", wl, 1);
        chk("wst_err", {31'd0, er}, 32'd0);
        chk("wst_rdata", rd, 32'd0);
        chk("wst_mem", mem[4], 32'hDEAD_BEEF);
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er, lat, wl);
        chk("wld_data", rd, 32'hDEAD_BEEF);
        chk("wld_err", {31'd0, er}, 32'd0);
        chk("wld_lat", lat, 3);

        @(posedge clk); #1;
        preload(12'd4, 32'h1122_3344);
        do_req(1'b1, 32'h13, 2'b00, 1'b0, 32'h1234_56A5, rd, er, lat, wl);
        chk("bst_lat", lat, 4);
        chk("bst_mem", mem[4], 32'hA522_3344);
        do_req(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, rd, er, lat, wl);
        chk("bld_signed", rd, 32'hFFFF_FFA5);
        do_req(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd, er, lat, wl);
        chk("bld_unsigned", rd, 32'h0000_00A5);
        do_req(1'b0, 32'h12, 2'b00, 1'b1, 32'h0, rd, er, lat, wl);
        chk("bld_lane2", rd, 32'h0000_0022);
        do_req(1'b0, 32'h10, 2'b00, 1'b0, 32'h0, rd, er, lat, wl);
        chk("bld_lane0", rd, 32'h0000_0044);

        @(posedge clk); #1;
        preload(12'd8, 32'h0);
        do_req(1'b1, 32'h22, 2'b01, 1'b0, 32'hABCD_8001, rd, er, lat, wl);
        chk("hst_mem", mem[8], 32'h8001_0000);
        do_req(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, rd, er, lat, wl);
        chk("hld_signed", rd, 32'hFFFF_8001);
        do_req(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, rd, er, lat, wl);
        chk("hld_unsigned", rd, 32'h0000_8001);
        do_req(1'b0, 32'h20, 2'b01, 1'b0, 32'h0, rd, er, lat, wl);
        chk("hld_low", rd, 32'h0);

        foreach (ev[i]) begin
            e0 = en_cnt;
            do_req(ev[i].we, ev[i].addr, ev[i].size, 1'b0, 32'hFFFF_FFFF, rd, er, lat, wl);
            chk({ev[i].tag, "_lat"}, lat, 1);
            chk({ev[i].tag, "_err"}, {31'd0, er}, 32'd1);
            chk({ev[i].tag, "_rdata"}, rd, 32'd0);
            @(posedge clk); #1;
            chk({ev[i].tag, "_sram_en"}, en_cnt - e0, 0);
        end

        rsp_ready = 1'b0;
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er, lat, wl);
        chk("hold_first", rd, 32'hA522_3344);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, 32'hA522_3344);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("release_ready", {31'd0, req_ready}, 32'd1);

        preload(12'd12, 32'h5566_7788);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 32'h0000_00EE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 10 && !sram_wen; k++) begin
            @(posedge clk); #1;
        end
        chk("mid_wr_reached", {31'd0, sram_wen}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_wr_wen_drop", {31'd0, sram_wen}, 32'd0);
        chk("mid_wr_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("mid_wr_mem_kept", mem[12], 32'h5566_7788);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("after_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("after_rst_mem", mem[12], 32'h5566_7788);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_data_port.md
Name: sram_data_port

Overview:
- Data-side access controller sitting directly upstream of the internal SRAM.
- Converts core load/store requests into SRAM word accesses:
  - byte addresses to word indices;
  - byte, half and word sizes;
  - sign or zero extension on loads;
  - read-modify-write for sub-word stores, because the SRAM has no byte enables.
- Owns SRAM read port A and the write port. Port B belongs to instruction fetch and is not touched.

Parameters:
- num_words, 4096: SRAM depth in words; must match the SRAM instance.
- l2_num_words, 12: log2(num_words); SRAM address width.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  block can accept a request this cycle.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  `WORD_SIZE  byte address.
- i_req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- i_req_wdata  in  `WORD_SIZE  store data, right-aligned.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer takes the response.
- o_rsp_rdata  out  `WORD_SIZE  load result, extended; 0 for stores and errors.
- o_rsp_err  out  1  misaligned, out-of-range or illegal size.
- o_sram_read_enable_A  out  1  to SRAM i_read_enable_A.
- o_sram_addr_read_A  out  l2_num_words  to SRAM i_addr_read_A.
- i_sram_data_read_A  in  `WORD_SIZE  from SRAM o_data_read_A.
- o_sram_write_enable  out  1  to SRAM i_write_enable.
- o_sram_addr_write  out  l2_num_words  to SRAM i_addr_write.
- o_sram_data_to_write  out  `WORD_SIZE  to SRAM i_data_to_write.

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - state = IDLE.
  - o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0.
  - All SRAM enables = 0, all SRAM addresses and data = 0.
  - o_req_ready = 0 while i_rst_n is low.
  - Reset mid-operation aborts at once. No SRAM write is issued after reset assertion. A pending response is dropped.
- FSM states: IDLE, RD, RD_WAIT, WR, RSP.
  - o_req_ready = 1 only in IDLE. No pipelining: at most one request in flight.
- Accept (IDLE, i_req_valid = 1):
  - Register the request fields.
  - widx = addr[l2_num_words+1:2]; off = addr[1:0].
- Error check at accept:
  - size = 11, half with off[0] = 1, word with off != 0, or any of addr[`WORD_SIZE-1:l2_num_words+2] nonzero → err.
  - On err: go to RSP with o_rsp_err = 1, o_rsp_rdata = 0, no SRAM access.
- Next state after a legal accept:
  - load → RD;
  - word store → WR;
  - byte/half store → RD.
- RD:
  - o_sram_read_enable_A = 1, o_sram_addr_read_A = widx; always go to RD_WAIT.
  - The SRAM captures data on this cycle's closing edge.
- RD_WAIT: i_sram_data_read_A is valid this cycle.
  - Load: select the lane by off (little-endian: byte k = bits 8k+7:8k; half at off 0 or 2), extend per i_req_unsigned, register into o_rsp_rdata, go to RSP.
  - Sub-word store: register the merged word (read data with the addressed byte/half lane replaced by wdata[7:0] / wdata[15:0]), go to WR.
- WR:
  - o_sram_write_enable = 1, o_sram_addr_write = widx, o_sram_data_to_write = full wdata (word store) or the merged word.
  - Go to RSP with o_rsp_rdata = 0, o_rsp_err = 0.
- RSP:
  - o_rsp_valid = 1; o_rsp_rdata and o_rsp_err are held stable until i_rsp_ready = 1, then go to IDLE.
  - o_rsp_valid drops on the same edge.
- SRAM strobes:
  - Decoded combinationally from the registered state only; never from i_req_*.
  - Enables are 0 in every state other than the one listed above.
- Latency (edges from the accept edge to o_rsp_valid rising):
  - load 3; word store 2; sub-word store 4; error 1.
  - With i_rsp_ready tied 1, the next accept is possible one cycle after o_rsp_valid.
- Ordering:
  - A store's write completes before its response. A load issued after a store response observes the stored data; there is no forwarding path.
- o_rsp_rdata bits above the accessed size:
  - sign copies of bit 7/15 when i_req_unsigned = 0;
  - zeros otherwise.

Test Plan:
- Word store addr 0x10 data 0xDEADBEEF, then word load 0x10:
  - write at widx 4 two edges after accept;
  - load response 0xDEADBEEF, err 0, latency 3.
- Byte store 0xA5 to 0x13 over 0x11223344, then loads of 0x13:
  - SRAM word becomes 0xA5223344;
  - signed byte load 0x13 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Half store 0x8001 to 0x22 over 0, then half loads of 0x22:
  - signed → 0xFFFF8001; unsigned → 0x00008001;
  - half load of 0x20 → 0.
- Error requests, each: response after 1 edge, err 1, rdata 0, SRAM enables never high.
  - word load 0x02 (misaligned);
  - half store 0x05 (misaligned);
  - size 11;
  - word load 0x4000 (out of range for 4096 words).
- Hold i_rsp_ready = 0 for 5 cycles on a load response:
  - o_rsp_valid and o_rsp_rdata stable, o_req_ready 0 throughout;
  - release → IDLE next edge.
- Assert i_rst_n low while in WR of a sub-word store:
  - o_sram_write_enable falls immediately;
  - target word keeps its old value;
  - after release, o_req_ready 1 and o_rsp_valid 0.
